// File: rtl/patch_rot_coord_gen.sv
// -----------------------------------------------------------------------------
// patch_rot_coord_gen
//
// Streams rotated, centred sample coordinates for one square descriptor patch.
// Cosine and sine are captured per keypoint on an accepted start. The block
// then walks the 2^PATCH_LOG2 x 2^PATCH_LOG2 patch in raster order (column is
// the fast index) and emits one signed rotated (x, y) pair per cycle under
// valid/ready backpressure.
//
// Rotation for centred indices u = col - H, v = row - H (H = 2^(PATCH_LOG2-1)):
//     xr =  u*c + v*s
//     yr = -u*s + v*c
// It is evaluated incrementally with adders only: a row-base accumulator pair
// and a column accumulator pair.
//
// Ports:
//   clk        clock, single domain
//   rst        synchronous, active-high reset
//   start      single-cycle request, honoured only while busy = 0
//   cos_in     signed cosine (FRAC fractional bits), captured on accepted start
//   sin_in     signed sine   (FRAC fractional bits), captured on accepted start
//   out_valid  out_x/out_y/out_addr/out_last carry a sample
//   out_ready  consumer accepts the current sample
//   out_x      signed rotated x, rounded, offset and saturated
//   out_y      signed rotated y, rounded, offset and saturated
//   out_addr   {row, col} of the current sample
//   out_last   final sample of the patch
//   busy       a patch is in progress (LOAD or RUN)
//   done       one-cycle pulse in the cycle after the last handshake
// -----------------------------------------------------------------------------
module patch_rot_coord_gen #(
    parameter int PATCH_LOG2 = 4,
    parameter int CS_W       = 14,
    parameter int FRAC       = 12,
    parameter int OUT_W      = 5,
    parameter int OFFSET     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [CS_W-1:0]       cos_in,
    input  logic signed [CS_W-1:0]       sin_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_W-1:0]      out_x,
    output logic signed [OUT_W-1:0]      out_y,
    output logic [2*PATCH_LOG2-1:0]      out_addr,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    // Two guard bits above CS_W + PATCH_LOG2 keep |u*c + v*s| representable
    // for |c|, |s| <= 2^FRAC.
    localparam int ACC_W = CS_W + PATCH_LOG2 + 2;
    localparam int IDX_W = PATCH_LOG2;

    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    // Rounding constant 2^(FRAC-1) at the widened rounding width.
    localparam logic signed [ACC_W:0] RND_HALF =
        {{(ACC_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

    // Offset and saturation limits at the post-offset width.
    localparam logic signed [ACC_W+1:0] OFF_EXT = (ACC_W+2)'(OFFSET);
    localparam logic signed [ACC_W+1:0] SAT_MAX =
        {{(ACC_W+3-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W+1:0] SAT_MIN =
        {{(ACC_W+3-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Accumulator -> output coordinate: round half up with an arithmetic
    // shift, add OFFSET, then clamp to the signed OUT_W range.
    // -------------------------------------------------------------------------
    function automatic logic signed [OUT_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W:0]   rnd_sum;
        logic signed [ACC_W:0]   rnd;
        logic signed [ACC_W+1:0] biased;
        logic signed [OUT_W-1:0] res;
        rnd_sum = $signed({acc[ACC_W-1], acc}) + RND_HALF;
        rnd     = rnd_sum >>> FRAC;
        biased  = $signed({rnd[ACC_W], rnd}) + OFF_EXT;
        if (biased > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (biased < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end else begin
            res = biased[OUT_W-1:0];
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state_q,     state_d;
    logic signed [CS_W-1:0]  cos_q,       cos_d;
    logic signed [CS_W-1:0]  sin_q,       sin_d;
    logic [IDX_W-1:0]        row_q,       row_d;
    logic [IDX_W-1:0]        col_q,       col_d;
    logic signed [ACC_W-1:0] base_x_q,    base_x_d;
    logic signed [ACC_W-1:0] base_y_q,    base_y_d;
    logic signed [ACC_W-1:0] acc_x_q,     acc_x_d;
    logic signed [ACC_W-1:0] acc_y_q,     acc_y_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_x_q,     out_x_d;
    logic signed [OUT_W-1:0] out_y_q,     out_y_d;
    logic                    out_last_q,  out_last_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic signed [ACC_W-1:0] c_ext_s;
    logic signed [ACC_W-1:0] s_ext_s;
    logic signed [ACC_W-1:0] load_x_s;
    logic signed [ACC_W-1:0] load_y_s;
    logic signed [ACC_W-1:0] col_x_s;
    logic signed [ACC_W-1:0] col_y_s;
    logic signed [ACC_W-1:0] row_x_s;
    logic signed [ACC_W-1:0] row_y_s;
    logic [IDX_W-1:0]        col_inc_s;
    logic [IDX_W-1:0]        row_inc_s;
    logic                    handshake_s;

    // Sign-extended coefficients and the candidate next accumulator values.
    always_comb begin
        c_ext_s   = {{(ACC_W-CS_W){cos_q[CS_W-1]}}, cos_q};
        s_ext_s   = {{(ACC_W-CS_W){sin_q[CS_W-1]}}, sin_q};
        // Top-left corner u = v = -H:
        //   x = -H*(c + s), y = H*(s - c), H a power of two.
        load_x_s  = -((c_ext_s + s_ext_s) <<< (PATCH_LOG2-1));
        load_y_s  = (s_ext_s - c_ext_s) <<< (PATCH_LOG2-1);
        // Column step (u + 1): x += c, y -= s.
        col_x_s   = acc_x_q + c_ext_s;
        col_y_s   = acc_y_q - s_ext_s;
        // Row step (v + 1) applied to the row base: x += s, y += c.
        row_x_s   = base_x_q + s_ext_s;
        row_y_s   = base_y_q + c_ext_s;
        col_inc_s = col_q + IDX_ONE;
        row_inc_s = row_q + IDX_ONE;
        handshake_s = out_valid_q & out_ready;
    end

    // Next-state and next-output logic for the IDLE/LOAD/RUN sequencer.
    always_comb begin
        state_d     = state_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        row_d       = row_q;
        col_d       = col_q;
        base_x_d    = base_x_q;
        base_y_d    = base_y_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cos_d   = cos_in;
                    sin_d   = sin_in;
                    row_d   = {IDX_W{1'b0}};
                    col_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end

            ST_LOAD: begin
                // Sample 0 is produced straight from the corner base so the
                // first valid appears in the cycle right after LOAD.
                base_x_d    = load_x_s;
                base_y_d    = load_y_s;
                acc_x_d     = load_x_s;
                acc_y_d     = load_y_s;
                out_x_d     = round_sat(load_x_s);
                out_y_d     = round_sat(load_y_s);
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                state_d     = ST_RUN;
            end

            ST_RUN: begin
                if (handshake_s) begin
                    if (out_last_q) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_x_d     = {OUT_W{1'b0}};
                        out_y_d     = {OUT_W{1'b0}};
                        row_d       = {IDX_W{1'b0}};
                        col_d       = {IDX_W{1'b0}};
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else if (col_q == IDX_MAX) begin
                        // Row wrap: advance the row base and reload the
                        // column accumulators from it.
                        row_d      = row_inc_s;
                        col_d      = {IDX_W{1'b0}};
                        base_x_d   = row_x_s;
                        base_y_d   = row_y_s;
                        acc_x_d    = row_x_s;
                        acc_y_d    = row_y_s;
                        out_x_d    = round_sat(row_x_s);
                        out_y_d    = round_sat(row_y_s);
                        out_last_d = 1'b0;
                    end else begin
                        col_d      = col_inc_s;
                        acc_x_d    = col_x_s;
                        acc_y_d    = col_y_s;
                        out_x_d    = round_sat(col_x_s);
                        out_y_d    = round_sat(col_y_s);
                        out_last_d = (row_q == IDX_MAX) && (col_inc_s == IDX_MAX);
                    end
                end else begin
                    // Stalled or idle consumer: hold everything.
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any patch in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cos_q       <= {CS_W{1'b0}};
            sin_q       <= {CS_W{1'b0}};
            row_q       <= {IDX_W{1'b0}};
            col_q       <= {IDX_W{1'b0}};
            base_x_q    <= {ACC_W{1'b0}};
            base_y_q    <= {ACC_W{1'b0}};
            acc_x_q     <= {ACC_W{1'b0}};
            acc_y_q     <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
            out_x_q     <= {OUT_W{1'b0}};
            out_y_q     <= {OUT_W{1'b0}};
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            row_q       <= row_d;
            col_q       <= col_d;
            base_x_q    <= base_x_d;
            base_y_q    <= base_y_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_addr  = {row_q, col_q};
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_patch_rot_coord_gen.sv
// -----------------------------------------------------------------------------
// Bench for patch_rot_coord_gen. Two instances share all inputs: one with the
// default OFFSET and one with OFFSET = 8. Expected samples come from a direct
// rotate-round-saturate model and are queued when a start is issued; a
// negedge monitor pops and compares on each handshake, and also checks
// timing, stall stability, done and reset behaviour.
// -----------------------------------------------------------------------------
module tb_patch_rot_coord_gen;

    localparam int PL    = 4;
    localparam int CS_W  = 14;
    localparam int FRAC  = 12;
    localparam int OUT_W = 5;
    localparam int AW    = 2 * PL;
    localparam int SIDE  = 1 << PL;
    localparam int HALF  = 1 << (PL - 1);
    localparam int SMAX  = (1 << (OUT_W - 1)) - 1;
    localparam int SMIN  = -(1 << (OUT_W - 1));
    localparam int OFF2  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic signed [CS_W-1:0]  cos_in;
    logic signed [CS_W-1:0]  sin_in;
    logic                    out_ready;
    logic                    out_valid, out_last, busy, done;
    logic signed [OUT_W-1:0] out_x, out_y;
    logic [AW-1:0]           out_addr;
    logic                    o_valid, o_last, o_busy, o_done;
    logic signed [OUT_W-1:0] o_x, o_y;
    logic [AW-1:0]           o_addr;

    patch_rot_coord_gen dut (
        .clk(clk), .rst(rst), .start(start), .cos_in(cos_in), .sin_in(sin_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    patch_rot_coord_gen #(.OFFSET(OFF2)) dut_off (
        .clk(clk), .rst(rst), .start(start), .cos_in(cos_in), .sin_in(sin_in),
        .out_valid(o_valid), .out_ready(out_ready), .out_x(o_x), .out_y(o_y),
        .out_addr(o_addr), .out_last(o_last), .busy(o_busy), .done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; int xo; int yo; int addr; bit last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rdy_rand = 1'b0;
    int   cap_x[SIDE*SIDE];
    int   cap_y[SIDE*SIDE];
    int   cap_xo[SIDE*SIDE];

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: rotate the centred index, round half up, offset, clamp.
    function automatic int ref_coord(input int acc, input int off);
        int r;
        r = ((acc + (1 << (FRAC - 1))) >>> FRAC) + off;
        if (r > SMAX) r = SMAX;
        if (r < SMIN) r = SMIN;
        return r;
    endfunction

    task automatic push_patch(input int c, input int s);
        exp_t e;
        for (int row = 0; row < SIDE; row++) begin
            for (int col = 0; col < SIDE; col++) begin
                int u, v, xr, yr;
                u = col - HALF;
                v = row - HALF;
                xr = u * c + v * s;
                yr = -u * s + v * c;
                e.x    = ref_coord(xr, 0);
                e.y    = ref_coord(yr, 0);
                e.xo   = ref_coord(xr, OFF2);
                e.yo   = ref_coord(yr, OFF2);
                e.addr = row * SIDE + col;
                e.last = (row == SIDE - 1) && (col == SIDE - 1);
                sb.push_back(e);
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   cyc = 0, n_acc = -1, stall_cnt = 0;
    bit   prev_rst = 1'b0, started = 1'b0, exp_done = 1'b0;
    bit   stall_pend = 1'b0, last_seen = 1'b0;
    logic [63:0] sv_snap;

    function automatic logic [63:0] snap();
        return {35'd0, out_x, out_y, out_addr, out_last, o_x, o_y};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (prev_rst) begin
            chk(!out_valid && !busy && !done && !out_last, "reset_ctrl",
                int'({out_valid, busy, done, out_last}), 0);
            chk(out_x == 0 && out_y == 0 && out_addr == 0, "reset_data",
                int'({out_x, out_y, out_addr}), 0);
            started = 1'b1;
        end else if (started) begin
            chk(done === exp_done, "done_pulse", int'(done), int'(exp_done));
            if (exp_done) chk(!busy, "busy_after_done", int'(busy), 0);
            if (stall_pend) chk(out_valid && snap() == sv_snap, "stall_hold",
                                int'(snap() != sv_snap), 0);
            if (n_acc >= 0 && cyc == n_acc + 1)
                chk(busy && !out_valid, "load_cycle", int'({busy, out_valid}), 2);
            if (n_acc >= 0 && cyc == n_acc + 2)
                chk(out_valid, "first_valid", int'(out_valid), 1);
            if (n_acc >= 0 && out_valid && out_last && !last_seen) begin
                chk(cyc == n_acc + 257 + stall_cnt, "last_latency",
                    cyc - n_acc, 257 + stall_cnt);
                last_seen = 1'b1;
            end
        end
        exp_done   = 1'b0;
        stall_pend = 1'b0;
        if (rst) begin
            sb.delete();
            n_acc = -1;
        end else if (started) begin
            if (start && !busy) begin
                n_acc = cyc; stall_cnt = 0; last_seen = 1'b0;
            end
            if (out_valid && !out_ready) begin
                stall_pend = 1'b1;
                sv_snap    = snap();
                stall_cnt++;
            end else if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_sample", int'(out_addr), -1);
                end else begin
                    e = sb.pop_front();
                    chk(int'(out_x) == e.x, "x", int'(out_x), e.x);
                    chk(int'(out_y) == e.y, "y", int'(out_y), e.y);
                    chk(int'(o_x) == e.xo, "x_off", int'(o_x), e.xo);
                    chk(int'(o_y) == e.yo, "y_off", int'(o_y), e.yo);
                    chk(int'(out_addr) == e.addr, "addr", int'(out_addr), e.addr);
                    chk(out_last == e.last, "last", int'(out_last), int'(e.last));
                    cap_x[out_addr]  = int'(out_x);
                    cap_y[out_addr]  = int'(out_y);
                    cap_xo[out_addr] = int'(o_x);
                    if (e.last) exp_done = 1'b1;
                end
            end
        end
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic clear_cap();
        for (int i = 0; i < SIDE * SIDE; i++) begin
            cap_x[i] = 99; cap_y[i] = 99; cap_xo[i] = 99;
        end
    endtask

    task automatic do_start(input int c, input int s);
        int n = 0;
        while (busy && n < 2000) begin @(posedge clk); #1; n++; end
        if (busy) chk(1'b0, "start_wait_busy", 1, 0);
        start  = 1'b1;
        cos_in = CS_W'(c);
        sin_in = CS_W'(s);
        push_patch(c, s);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic pulse_ignored(input int c, input int s);
        chk(busy, "busy_during_run", int'(busy), 1);
        start  = 1'b1;
        cos_in = CS_W'(c);
        sin_in = CS_W'(s);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 3000) begin @(posedge clk); #1; n++; end
        chk(done, nm, int'(done), 1);
    endtask

    function automatic int rnd_cs();
        return int'($urandom_range(0, 8192)) - 4096;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cos_in = '0; sin_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Identity
        clear_cap();
        do_start(4096, 0);
        wait_done("done_identity");
        chk(cap_x[0] == -8 && cap_y[0] == -8, "id_s0", cap_x[0] * 100 + cap_y[0], -808);
        chk(cap_x[255] == 7 && cap_y[255] == 7, "id_s255", cap_x[255] * 100 + cap_y[255], 707);

        // 90 degrees
        clear_cap();
        do_start(0, 4096);
        wait_done("done_90");
        chk(cap_x[0] == -8 && cap_y[0] == 8, "r90_s0", cap_x[0] * 100 + cap_y[0], -792);
        chk(cap_x[1] == -8 && cap_y[1] == 7, "r90_s1", cap_x[1] * 100 + cap_y[1], -793);
        chk(cap_x[16] == -7 && cap_y[16] == 8, "r90_s16", cap_x[16] * 100 + cap_y[16], -692);

        // 45 degrees, plus saturation on the OFFSET=8 instance
        clear_cap();
        do_start(2896, 2896);
        wait_done("done_45");
        chk(cap_x[0] == -11 && cap_y[0] == 0, "r45_s0", cap_x[0] * 100 + cap_y[0], -1100);
        chk(cap_x[255] == 10 && cap_y[255] == 0, "r45_s255", cap_x[255] * 100 + cap_y[255], 1000);
        chk(cap_xo[255] == 15, "r45_off_sat", cap_xo[255], 15);

        // Backpressure: same 45-degree patch, then random coefficients
        rdy_rand = 1'b1;
        do_start(2896, 2896);
        wait_done("done_bp45");
        for (int k = 0; k < 3; k++) begin
            do_start(rnd_cs(), rnd_cs());
            wait_done("done_bp_rand");
        end
        rdy_rand = 1'b0;
        @(posedge clk); #1;

        // Starts during RUN are ignored; a start after done is honoured
        do_start(rnd_cs(), rnd_cs());
        repeat (10) @(posedge clk);
        #0 pulse_ignored(-4096, 1234);
        repeat (100) @(posedge clk);
        #0 pulse_ignored(3000, -2000);
        wait_done("done_ignore");
        do_start(-2896, 2896);
        wait_done("done_after_ignore");

        // Reset while sample 100 is presented
        do_start(rnd_cs(), rnd_cs());
        n = 0;
        while (!(out_valid && out_addr == AW'(100)) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk(out_valid && out_addr == AW'(100), "reach_s100", int'(out_addr), 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_start(rnd_cs(), rnd_cs());
        wait_done("done_after_rst");

        repeat (3) @(posedge clk);
        #1;
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/patch_rot_coord_gen.md
# patch_rot_coord_gen

Streams rotated, centred sample coordinates for one square descriptor patch. It replaces per-orientation coordinate ROMs with a single parametrised generator: cosine and sine are loaded per keypoint, and the block walks the patch in raster order, emitting one signed rotated (x, y) pair per cycle. It sits between the orientation-assignment stage, which supplies cos/sin, and the descriptor histogram builder, which consumes the coordinate stream under valid/ready backpressure.

## Interface
Parameters:
- PATCH_LOG2, 4: patch side = 2^PATCH_LOG2 (default 16x16 = 256 samples)
- CS_W, 14: signed width of cos_in/sin_in
- FRAC, 12: fractional bits of cos_in/sin_in; 1.0 = 2^FRAC
- OUT_W, 5: signed width of out_x/out_y
- OFFSET, 0: signed constant added to both rotated coordinates before saturation

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; accepted only while busy=0
- cos_in  in  CS_W  signed cosine, sampled on the accepted start
- sin_in  in  CS_W  signed sine, sampled on the accepted start
- out_valid  out  1  out_x/out_y/out_addr/out_last are valid
- out_ready  in  1  consumer accepts the current sample
- out_x  out  OUT_W  signed rotated x
- out_y  out  OUT_W  signed rotated y
- out_addr  out  2*PATCH_LOG2  {row, col} of the current sample
- out_last  out  1  marks the final sample of the patch
- busy  out  1  a patch is in progress
- done  out  1  one-cycle pulse after the last handshake

## Operation
- States:
  - IDLE: start -> LOAD; latch cos/sin; row = col = 0.
  - LOAD: initialise the accumulators; go to RUN.
  - RUN: emit samples; after the last handshake -> IDLE and pulse done.
- Centred indices: u = col - 2^(PATCH_LOG2-1), v = row - 2^(PATCH_LOG2-1).
- Rotation: xr = u*c + v*s, yr = -u*s + v*c.
- Incremental computation; no multipliers inside the walk:
  - Column step: x += c, y -= s.
  - Row step: the row base adds s to x and c to y; the column accumulators reload from the row base.
  - LOAD computes the base for u = v = -2^(PATCH_LOG2-1) using shift/negate only.
- Accumulator width: ACC_W = CS_W + PATCH_LOG2 + 2, signed; it never overflows for |c|,|s| <= 2^FRAC.
- Output arithmetic:
  - Rounding: ((acc + 2^(FRAC-1)) >>> FRAC), arithmetic shift (round half up).
  - Then add OFFSET.
  - Then saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Raster order: col is the fast index; out_addr = {row, col}; out_last = (row = col = max).
- Backpressure:
  - While out_valid=1 and out_ready=0, all outputs hold stable and the indices do not advance.
  - out_valid never drops until the sample is accepted.
- start while busy=1 is ignored; the latched cos/sin are unaffected.
- Reset:
  - rst mid-patch aborts the patch: next edge gives IDLE, with no done and no partial-sample output.
  - Reset values: out_valid=0, out_x=0, out_y=0, out_addr=0, out_last=0, busy=0, done=0.

## Timing
- Start accepted at edge T.
- busy=1 from T+1 (LOAD).
- First out_valid=1 at T+2.
- With out_ready held high: one sample per cycle, last sample valid at T+2+2^(2*PATCH_LOG2)-1 (T+257 by default).
- busy falls and done pulses in the cycle after the last handshake.
- A new start is accepted from the cycle busy=0 onward (earliest the cycle done=1); minimum gap between patches is 2 cycles.
- Each out_ready=0 cycle adds exactly one cycle of latency.
- Outputs are registered; there is no combinational path from out_ready to out_valid/data.

## Test plan
- Identity, cos=4096, sin=0, defaults: sample 0 -> (x,y)=(-8,-8), addr=0x00; sample 255 -> (7,7), addr=0xFF, out_last=1; done one cycle after the handshake.
- 90 degrees, cos=0, sin=4096:
  - sample 0 -> (-8,8);
  - sample 1 -> (-8,7);
  - sample 16 -> (-7,8).
- 45 degrees, cos=sin=2896:
  - sample 0 -> (-11,0);
  - sample 255 -> (10,0).
  - Same input with OFFSET=8: sample 255 x saturates to 15.
- Backpressure: toggle out_ready pseudo-randomly.
  - Sequence matches the ready-high run exactly.
  - Outputs are stable while stalled.
  - Total cycles = 257 + stall count.
- start pulses during RUN with different cos/sin: ignored; output unchanged; a second start after done produces the new patch.
- rst asserted at sample 100: next cycle out_valid=0, busy=0, no done; a following start produces a full, correct 256-sample patch.
